// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 8-entry register file write port.
// Zeroes every entry after reset, then shares the write port between the ALU (A)
// and memory-load (B) requesters with round-robin tie-breaking. Writes to r0 are
// swallowed silently; out-of-range writes are swallowed and counted.
//
// state | meaning
// INIT  | post-reset sweep, one zero write per cycle to idx 0..NUM_REGS-1
// ARB   | normal operation, combinational grant, registered write port
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              a_req,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic              regWrite,
  output logic [4:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              busy,
  output logic              drop_err,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  // One extra bit so a 32-entry file still compares correctly against 5-bit indices.
  localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  idx, idx_next;
  logic              rr_last, rr_last_next;   // 0 = A won last, 1 = B won last
  logic              reg_write_next;
  logic [4:0]        write_reg_next;
  logic [DATA_W-1:0] write_data_next;
  logic              busy_next;
  logic              drop_err_next;
  logic [CNT_W-1:0]  drop_count_next;

  logic              grant_a, grant_b;
  logic [4:0]        g_reg;
  logic [DATA_W-1:0] g_data;

  // Grant: lone requester wins; on a tie the one that did not win last time wins.
  // Held off while busy so the last sweep cycle never shows an ack.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_ARB && !busy) begin
      if (a_req && (!b_req || rr_last)) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ack  = grant_a;
  assign b_ack  = grant_b;
  assign g_reg  = grant_b ? b_reg  : a_reg;
  assign g_data = grant_b ? b_data : a_data;

  // Next-state and next registered outputs for the sweep and the arbitration phase.
  always_comb begin
    state_next      = state;
    idx_next        = idx;
    rr_last_next    = rr_last;
    reg_write_next  = 1'b0;
    write_reg_next  = writeReg;
    write_data_next = writeData;
    busy_next       = busy;
    drop_err_next   = 1'b0;
    drop_count_next = drop_count;

    case (state)
      ST_INIT: begin
        reg_write_next  = 1'b1;
        write_reg_next  = 5'(idx);
        write_data_next = '0;
        busy_next       = 1'b1;
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          state_next = ST_ARB;
        end else begin
          idx_next = idx + 1'b1;
        end
      end

      ST_ARB: begin
        // busy falls one cycle after the final sweep write is presented.
        busy_next = 1'b0;
        if (grant_a || grant_b) begin
          rr_last_next = grant_b;
          if (g_reg == 5'd0) begin
            // r0 is hard-wired; accept and discard quietly.
          end else if ({1'b0, g_reg} >= NUM_REGS_W) begin
            drop_err_next = 1'b1;
            if (drop_count != {CNT_W{1'b1}}) begin
              drop_count_next = drop_count + 1'b1;
            end
          end else begin
            reg_write_next  = 1'b1;
            write_reg_next  = g_reg;
            write_data_next = g_data;
          end
        end
      end

      default: begin
        state_next = ST_INIT;
        idx_next   = '0;
      end
    endcase
  end

  // State register and registered write port, synchronous active-low reset.
  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state      <= ST_INIT;
      idx        <= '0;
      rr_last    <= 1'b1;
      regWrite   <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      busy       <= 1'b1;
      drop_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      rr_last    <= rr_last_next;
      regWrite   <= reg_write_next;
      writeReg   <= write_reg_next;
      writeData  <= write_data_next;
      busy       <= busy_next;
      drop_err   <= drop_err_next;
      drop_count <= drop_count_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, grants, round-robin,
// r0 / out-of-range filtering, drop counter saturation, reset mid-sweep and mid-grant.
module tb_regfile_wb_arbiter;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_ack, b_ack;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        busy;
  logic        drop_err;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .a_req      (a_req),
    .a_reg      (a_reg),
    .a_data     (a_data),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_reg      (b_reg),
    .b_data     (b_data),
    .b_ack      (b_ack),
    .regWrite   (regWrite),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .busy       (busy),
    .drop_err   (drop_err),
    .drop_count (drop_count)
  );

  always #5 clock_in = ~clock_in;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    a_req  = 1'b0; a_reg = 5'd0; a_data = 32'h0;
    b_req  = 1'b0; b_reg = 5'd0; b_data = 32'h0;

    // 1. Reset for 3 cycles, then the init sweep.
    repeat (3) tick();
    check("rst_regwrite", 32'(regWrite), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_writereg", 32'(writeReg), 32'd0);
    check("rst_dropcnt", 32'(drop_count), 32'd0);
    check("rst_droperr", 32'(drop_err), 32'd0);
    reset = 1'b1;
    // Requests held during the sweep must not be acknowledged.
    a_req = 1'b1; a_reg = 5'd3; b_req = 1'b1; b_reg = 5'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("init_we_%0d", i), 32'(regWrite), 32'd1);
      check($sformatf("init_reg_%0d", i), 32'(writeReg), 32'(i));
      check($sformatf("init_data_%0d", i), writeData, 32'd0);
      check($sformatf("init_busy_%0d", i), 32'(busy), 32'd1);
      check($sformatf("init_ack_%0d", i), 32'({a_ack, b_ack}), 32'd0);
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    check("post_init_busy", 32'(busy), 32'd0);
    check("post_init_we", 32'(regWrite), 32'd0);

    // 2. Single A write.
    a_req = 1'b1; a_reg = 5'd3; a_data = 32'hDEADBEEF;
    #1;
    check("t2_a_ack", 32'(a_ack), 32'd1);
    check("t2_b_ack", 32'(b_ack), 32'd0);
    tick();
    a_req = 1'b0;
    check("t2_we", 32'(regWrite), 32'd1);
    check("t2_reg", 32'(writeReg), 32'd3);
    check("t2_data", writeData, 32'hDEADBEEF);
    #1;
    check("t2_idle_ack", 32'({a_ack, b_ack}), 32'd0);

    // Single B write: B becomes last winner so the next tie goes to A.
    b_req = 1'b1; b_reg = 5'd5; b_data = 32'h5555_0005;
    #1;
    check("b_only_ack", 32'(b_ack), 32'd1);
    tick();
    b_req = 1'b0;
    check("b_only_we", 32'(regWrite), 32'd1);
    check("b_only_reg", 32'(writeReg), 32'd5);
    check("b_only_data", writeData, 32'h5555_0005);

    // 3. Both requesting for 4 cycles: A,B,A,B.
    a_req = 1'b1; a_reg = 5'd1; a_data = 32'h0000_0011;
    b_req = 1'b1; b_reg = 5'd2; b_data = 32'h0000_0022;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_a_ack_%0d", k), 32'(a_ack), 32'((k % 2) == 0));
      check($sformatf("rr_b_ack_%0d", k), 32'(b_ack), 32'((k % 2) == 1));
      tick();
      check($sformatf("rr_we_%0d", k), 32'(regWrite), 32'd1);
      check($sformatf("rr_reg_%0d", k), 32'(writeReg), ((k % 2) == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr_data_%0d", k), writeData,
            ((k % 2) == 0) ? 32'h0000_0011 : 32'h0000_0022);
    end
    a_req = 1'b0; b_req = 1'b0;

    // 4. r0 write is swallowed without error.
    b_req = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    #1;
    check("r0_ack", 32'(b_ack), 32'd1);
    tick();
    b_req = 1'b0;
    check("r0_we", 32'(regWrite), 32'd0);
    check("r0_err", 32'(drop_err), 32'd0);
    check("r0_cnt", 32'(drop_count), 32'd0);
    check("r0_hold_reg", 32'(writeReg), 32'd2);

    // Index 9 is out of range.
    b_req = 1'b1; b_reg = 5'd9;
    #1;
    check("r9_ack", 32'(b_ack), 32'd1);
    tick();
    b_req = 1'b0;
    check("r9_we", 32'(regWrite), 32'd0);
    check("r9_err", 32'(drop_err), 32'd1);
    check("r9_cnt", 32'(drop_count), 32'd1);
    tick();
    check("r9_err_pulse", 32'(drop_err), 32'd0);
    check("r9_cnt_hold", 32'(drop_count), 32'd1);

    // Boundaries: 8 is the first invalid index, 7 the last valid one.
    a_req = 1'b1; a_reg = 5'd8; a_data = 32'h8;
    tick();
    check("r8_we", 32'(regWrite), 32'd0);
    check("r8_err", 32'(drop_err), 32'd1);
    check("r8_cnt", 32'(drop_count), 32'd2);
    a_reg = 5'd7; a_data = 32'h7777_7777;
    tick();
    a_req = 1'b0;
    check("r7_we", 32'(regWrite), 32'd1);
    check("r7_reg", 32'(writeReg), 32'd7);
    check("r7_data", writeData, 32'h7777_7777);
    check("r7_err", 32'(drop_err), 32'd0);

    // 5. Drive the counter to 255 with back-to-back index-12 drops, then one more.
    a_req = 1'b1; a_reg = 5'd12;
    repeat (253) tick();
    check("sat_reach", 32'(drop_count), 32'd255);
    a_reg = 5'd31;
    tick();
    a_req = 1'b0;
    check("sat_hold", 32'(drop_count), 32'd255);
    check("sat_err", 32'(drop_err), 32'd1);
    check("sat_we", 32'(regWrite), 32'd0);
    tick();
    a_req = 1'b1; a_reg = 5'd12;
    tick();
    a_req = 1'b0;
    check("sat_hold2", 32'(drop_count), 32'd255);
    check("sat_err2", 32'(drop_err), 32'd1);

    // 6a. Reset while A is granted: the write must not happen.
    tick();
    a_req = 1'b1; a_reg = 5'd4; a_data = 32'h4444_4444;
    #1;
    check("rg_ack_before", 32'(a_ack), 32'd1);
    reset = 1'b0;
    tick();
    check("rg_we", 32'(regWrite), 32'd0);
    check("rg_busy", 32'(busy), 32'd1);
    check("rg_reg", 32'(writeReg), 32'd0);
    check("rg_data", writeData, 32'd0);
    check("rg_cnt", 32'(drop_count), 32'd0);
    check("rg_err", 32'(drop_err), 32'd0);
    check("rg_ack_after", 32'(a_ack), 32'd0);
    reset = 1'b1;
    a_req = 1'b0;

    // 6b. Restart sweep, then reset during its fourth write.
    tick();
    check("rs_reg0", 32'(writeReg), 32'd0);
    check("rs_we0", 32'(regWrite), 32'd1);
    tick();
    tick();
    tick();
    check("rs_reg3", 32'(writeReg), 32'd3);
    reset = 1'b0;
    tick();
    check("rs_rst_we", 32'(regWrite), 32'd0);
    check("rs_rst_busy", 32'(busy), 32'd1);
    check("rs_rst_reg", 32'(writeReg), 32'd0);
    reset = 1'b1;
    tick();
    check("rs_restart_reg", 32'(writeReg), 32'd0);
    check("rs_restart_we", 32'(regWrite), 32'd1);
    tick();
    check("rs_restart_reg1", 32'(writeReg), 32'd1);
    check("rs_restart_busy", 32'(busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
